mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the core's single memory port. The instruction-fetch stage and the MEM stage share one memory access channel. The arbiter grants one requester at a time and drives a single outstanding bus transaction. It then returns the response, registered, to the requester that owns the transaction. It sits between `ysyx_22040931_IF`/`ysyx_22040931_MEM` and the DPI-C/bus memory model in `top`.

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and MEM stage, one transaction in flight.
// Define YSYX_22040931_ARB_STARVE_EN to stop data requests from starving fetch.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  input  logic                if_flush,
  output logic                if_rsp_valid,
  output logic [31:0]         if_rsp_instr,
  input  logic                mem_req_valid,
  output logic                mem_req_ready,
  input  logic                mem_req_wr,
  input  logic [ADDR_W-1:0]   mem_req_addr,
  input  logic [DATA_W-1:0]   mem_req_wdata,
  input  logic [DATA_W/8-1:0] mem_req_wmask,
  output logic                mem_rsp_valid,
  output logic [DATA_W-1:0]   mem_rsp_data,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic                bus_req_wr,
  output logic [ADDR_W-1:0]   bus_req_addr,
  output logic [DATA_W-1:0]   bus_req_wdata,
  output logic [DATA_W/8-1:0] bus_req_wmask,
  input  logic                bus_rsp_valid,
  input  logic [DATA_W-1:0]   bus_rsp_data,
  output logic [1:0]          owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_MEM  = 2'b10;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_owner;
  logic                  r_drop;
  logic                  r_bus_wr;
  logic [ADDR_W-1:0]     r_bus_addr;
  logic [DATA_W-1:0]     r_bus_wdata;
  logic [DATA_W/8-1:0]   r_bus_wmask;
  logic                  r_if_rsp_valid;
  logic [31:0]           r_if_rsp_instr;
  logic                  r_mem_rsp_valid;
  logic [DATA_W-1:0]     r_mem_rsp_data;

  logic                  w_idle;
  logic                  w_force_if;
  logic                  w_grant_if;
  logic                  w_grant_mem;
  logic                  w_drop_now;
  logic                  w_rsp_done;

  assign w_idle      = (r_state == S_IDLE);
  assign w_grant_mem = w_idle & mem_req_valid & ~w_force_if;
  assign w_grant_if  = w_idle & if_req_valid & (~mem_req_valid | w_force_if);
  assign w_rsp_done  = (r_state == S_RSP) & bus_rsp_valid;
  // A flush arriving together with the bus response still suppresses it.
  assign w_drop_now  = r_drop | (if_flush & ~w_idle & (r_owner == OWN_IF));

`ifdef YSYX_22040931_ARB_STARVE_EN
  localparam logic [2:0] LP_STARVE_LIMIT = 3'(STARVE_LIMIT);
  logic [2:0] r_starve_cnt;

  assign w_force_if = (r_starve_cnt == LP_STARVE_LIMIT) & if_req_valid & mem_req_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_starve_cnt <= 3'd0;
    end else if (w_grant_if) begin
      r_starve_cnt <= 3'd0;
    end else if (w_grant_mem) begin
      if (!if_req_valid) begin
        r_starve_cnt <= 3'd0;
      end else if (r_starve_cnt != 3'd7) begin
        r_starve_cnt <= r_starve_cnt + 3'd1;
      end
    end
  end
`else
  logic w_unused_starve_cfg;
  assign w_unused_starve_cfg = (STARVE_LIMIT == 0);
  assign w_force_if          = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    bus_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    if_req_ready  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        mem_req_ready = w_grant_mem;
        if_req_ready  = w_grant_if;
        if (w_grant_mem || w_grant_if) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        bus_req_valid = 1'b1;
        if (bus_req_ready) begin
          w_state_next = S_RSP;
        end
      end
      S_RSP: begin
        if (bus_rsp_valid) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_owner         <= OWN_NONE;
      r_drop          <= 1'b0;
      r_bus_wr        <= 1'b0;
      r_bus_addr      <= '0;
      r_bus_wdata     <= '0;
      r_bus_wmask     <= '0;
      r_if_rsp_valid  <= 1'b0;
      r_if_rsp_instr  <= 32'd0;
      r_mem_rsp_valid <= 1'b0;
      r_mem_rsp_data  <= '0;
    end else begin
      r_if_rsp_valid  <= 1'b0;
      r_mem_rsp_valid <= 1'b0;
      if (w_grant_mem) begin
        r_owner     <= OWN_MEM;
        r_bus_wr    <= mem_req_wr;
        r_bus_addr  <= mem_req_addr;
        r_bus_wdata <= mem_req_wdata;
        r_bus_wmask <= mem_req_wmask;
      end else if (w_grant_if) begin
        r_owner     <= OWN_IF;
        r_bus_wr    <= 1'b0;
        r_bus_addr  <= if_req_addr;
        r_bus_wdata <= '0;
        r_bus_wmask <= '0;
      end
      if (!w_idle) begin
        r_drop <= w_drop_now;
      end
      if (w_rsp_done) begin
        r_owner <= OWN_NONE;
        r_drop  <= 1'b0;
        if (r_owner == OWN_IF) begin
          if (!w_drop_now) begin
            r_if_rsp_valid <= 1'b1;
            r_if_rsp_instr <= r_bus_addr[2] ? bus_rsp_data[63:32] : bus_rsp_data[31:0];
          end
        end else if (r_owner == OWN_MEM) begin
          r_mem_rsp_valid <= 1'b1;
          r_mem_rsp_data  <= r_bus_wr ? '0 : bus_rsp_data;
        end
      end
    end
  end

  assign if_rsp_valid  = r_if_rsp_valid;
  assign if_rsp_instr  = r_if_rsp_instr;
  assign mem_rsp_valid = r_mem_rsp_valid;
  assign mem_rsp_data  = r_mem_rsp_data;
  assign bus_req_wr    = r_bus_wr;
  assign bus_req_addr  = r_bus_addr;
  assign bus_req_wdata = r_bus_wdata;
  assign bus_req_wmask = r_bus_wmask;
  assign owner         = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, data priority, stalls, flush, reset, starvation.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_flush;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_instr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wr;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_wr;
  logic [63:0] bus_req_addr;
  logic [63:0] bus_req_wdata;
  logic [7:0]  bus_req_wmask;
  logic        bus_rsp_valid;
  logic [63:0] bus_rsp_data;
  logic [1:0]  owner;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_instr(if_rsp_instr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_wr(bus_req_wr),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data), .owner(owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [1:0] exp_owner;

  initial begin
    reset = 1'b0; if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
    mem_req_valid = 1'b0; mem_req_wr = 1'b0; mem_req_addr = '0; mem_req_wdata = '0;
    mem_req_wmask = '0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = '0;
    tick(); tick();

    // reset state
    check_val("rst_owner", 64'(owner), 64'd0);
    check_val("rst_bus_valid", 64'(bus_req_valid), 64'd0);
    check_val("rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
    check_val("rst_mem_rsp_valid", 64'(mem_rsp_valid), 64'd0);
    check_val("rst_instr", 64'(if_rsp_instr), 64'd0);
    check_val("rst_bus_addr", bus_req_addr, 64'd0);
    reset = 1'b1;
    tick();

    // fetch only, upper word
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0004;
    #1 check_val("f1_if_ready", 64'(if_req_ready), 64'd1);
    tick();
    check_val("f1_bus_valid", 64'(bus_req_valid), 64'd1);
    check_val("f1_owner", 64'(owner), 64'd1);
    check_val("f1_bus_addr", bus_req_addr, 64'h8000_0004);
    check_val("f1_bus_wmask", 64'(bus_req_wmask), 64'd0);
    check_val("f1_if_ready_busy", 64'(if_req_ready), 64'd0);
    if_req_valid = 1'b0; bus_req_ready = 1'b1;
    tick();
    check_val("f1_rsp_state_busvalid", 64'(bus_req_valid), 64'd0);
    check_val("f1_rsp_owner", 64'(owner), 64'd1);
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 64'h1111_2222_3333_4444;
    tick();
    check_val("f1_rsp_valid", 64'(if_rsp_valid), 64'd1);
    check_val("f1_instr", 64'(if_rsp_instr), 64'h1111_2222);
    check_val("f1_owner_clear", 64'(owner), 64'd0);
    bus_rsp_valid = 1'b0; bus_rsp_data = '0;
    tick();
    check_val("f1_pulse_end", 64'(if_rsp_valid), 64'd0);
    check_val("f1_instr_hold", 64'(if_rsp_instr), 64'h1111_2222);

    // both valid: store wins, then fetch
    mem_req_valid = 1'b1; mem_req_wr = 1'b1; mem_req_addr = 64'h100;
    mem_req_wdata = 64'hDEAD_BEEF_0BAD_F00D; mem_req_wmask = 8'hF0;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0010;
    #1 check_val("st_mem_ready", 64'(mem_req_ready), 64'd1);
    check_val("st_if_ready", 64'(if_req_ready), 64'd0);
    tick();
    check_val("st_owner", 64'(owner), 64'd2);
    check_val("st_bus_wr", 64'(bus_req_wr), 64'd1);
    check_val("st_bus_wmask", 64'(bus_req_wmask), 64'hF0);
    check_val("st_bus_wdata", bus_req_wdata, 64'hDEAD_BEEF_0BAD_F00D);
    mem_req_valid = 1'b0; bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    check_val("st_rsp_valid", 64'(mem_rsp_valid), 64'd1);
    check_val("st_rsp_data", mem_rsp_data, 64'd0);
    check_val("st_no_if_rsp", 64'(if_rsp_valid), 64'd0);
    check_val("st_then_if_ready", 64'(if_req_ready), 64'd1);
    bus_rsp_valid = 1'b0; bus_rsp_data = '0;
    tick();
    check_val("f2_owner", 64'(owner), 64'd1);
    check_val("f2_bus_addr", bus_req_addr, 64'h8000_0010);
    check_val("f2_bus_wr", 64'(bus_req_wr), 64'd0);

    // bus_req_ready stalled for 5 cycles while data keeps asking
    if_req_valid = 1'b0; mem_req_valid = 1'b1; mem_req_wr = 1'b0; mem_req_addr = 64'h300;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val($sformatf("stall%0d_bus_valid", i), 64'(bus_req_valid), 64'd1);
      check_val($sformatf("stall%0d_bus_addr", i), bus_req_addr, 64'h8000_0010);
      check_val($sformatf("stall%0d_mem_ready", i), 64'(mem_req_ready), 64'd0);
      tick();
    end
    mem_req_valid = 1'b0; bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 64'h0123_4567_89AB_CDEF;
    tick();
    check_val("f2_rsp_valid", 64'(if_rsp_valid), 64'd1);
    check_val("f2_instr_lo", 64'(if_rsp_instr), 64'h89AB_CDEF);
    bus_rsp_valid = 1'b0; bus_rsp_data = '0;

    // flush during RSP
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0004;
    tick();
    if_req_valid = 1'b0; bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0; if_flush = 1'b1;
    tick();
    if_flush = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 64'h9999_8888_7777_6666;
    tick();
    check_val("fl_no_rsp", 64'(if_rsp_valid), 64'd0);
    check_val("fl_owner", 64'(owner), 64'd0);
    check_val("fl_instr_hold", 64'(if_rsp_instr), 64'h89AB_CDEF);
    bus_rsp_valid = 1'b0; bus_rsp_data = '0;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0004;
    tick();
    if_req_valid = 1'b0; bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 64'h5555_6666_7777_8888;
    tick();
    check_val("fl_next_valid", 64'(if_rsp_valid), 64'd1);
    check_val("fl_next_instr", 64'(if_rsp_instr), 64'h5555_6666);
    bus_rsp_valid = 1'b0; bus_rsp_data = '0;

    // load returns bus data
    mem_req_valid = 1'b1; mem_req_wr = 1'b0; mem_req_addr = 64'h208;
    tick();
    mem_req_valid = 1'b0; bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 64'hCAFE_BABE_1234_5678;
    tick();
    check_val("ld_rsp_valid", 64'(mem_rsp_valid), 64'd1);
    check_val("ld_rsp_data", mem_rsp_data, 64'hCAFE_BABE_1234_5678);
    bus_rsp_valid = 1'b0; bus_rsp_data = '0;

    // reset in RSP, late bus response ignored
    mem_req_valid = 1'b1; mem_req_addr = 64'h200;
    tick();
    mem_req_valid = 1'b0; bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0; reset = 1'b0;
    tick();
    reset = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_data = 64'hFFFF_0000_FFFF_0000;
    tick();
    check_val("rr_mem_rsp_valid", 64'(mem_rsp_valid), 64'd0);
    check_val("rr_mem_rsp_data", mem_rsp_data, 64'd0);
    check_val("rr_owner", 64'(owner), 64'd0);
    check_val("rr_bus_valid", 64'(bus_req_valid), 64'd0);
    check_val("rr_bus_addr", bus_req_addr, 64'd0);
    check_val("rr_instr", 64'(if_rsp_instr), 64'd0);
    bus_rsp_valid = 1'b0; bus_rsp_data = '0;
    tick();

    // both requesters held valid across five grants
    mem_req_valid = 1'b1; mem_req_wr = 1'b0; mem_req_addr = 64'h400;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0020;
    for (int g = 0; g < 5; g++) begin
      tick();
`ifdef YSYX_22040931_ARB_STARVE_EN
      exp_owner = (g == 4) ? 2'b01 : 2'b10;
`else
      exp_owner = 2'b10;
`endif
      check_val($sformatf("starve_grant%0d_owner", g), 64'(owner), 64'(exp_owner));
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 64'h0;
      tick();
      bus_rsp_valid = 1'b0;
    end
    mem_req_valid = 1'b0; if_req_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
